// File: rtl/expr_eval_if.sv
// rtl/expr_eval_if.sv - character-in / result-out bundle for the expression evaluator
interface expr_eval_if #(
    parameter int W = 16
);
    logic [7:0]   in;
    logic         in_valid;
    logic [W-1:0] result;
    logic         done;
    logic         err;
    logic         busy;

    modport master (
        output in,
        output in_valid,
        input  result,
        input  done,
        input  err,
        input  busy
    );

    modport slave (
        input  in,
        input  in_valid,
        output result,
        output done,
        output err,
        output busy
    );
endinterface

// File: rtl/expr_eval.sv
// rtl/expr_eval.sv - single-digit '+'/'*' expression evaluator with '*' precedence
module expr_eval #(
    parameter int W = 16
) (
    input  logic      clk,
    input  logic      clr,
    expr_eval_if.slave bus
);
    localparam logic [1:0] S_START = 2'd0;
    localparam logic [1:0] S_OP    = 2'd1;
    localparam logic [1:0] S_DIG   = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [W-1:0] r_sum;
    logic [W-1:0] r_prod;
    logic         r_mulpend;
    logic [W-1:0] r_result;
    logic         r_done;
    logic         r_err;
    logic         r_busy;

    logic         w_is_dig;
    logic         w_is_add;
    logic         w_is_mul;
    logic         w_is_eq;
    logic [7:0]   w_dig_raw;
    logic [W-1:0] w_d;

    assign w_is_dig  = (bus.in >= 8'd48) && (bus.in <= 8'd57);
    assign w_is_add  = (bus.in == 8'd43);
    assign w_is_mul  = (bus.in == 8'd42);
    assign w_is_eq   = (bus.in == 8'd61);
    assign w_dig_raw = bus.in - 8'd48;
    assign w_d       = W'(w_dig_raw);

    always_comb begin
        w_state_nxt = r_state;
        if (bus.in_valid) begin
            case (r_state)
                S_START: begin
                    if (w_is_dig)     w_state_nxt = S_OP;
                    else if (!w_is_eq) w_state_nxt = S_ERR;
                end
                S_OP: begin
                    if (w_is_add || w_is_mul) w_state_nxt = S_DIG;
                    else if (w_is_eq)         w_state_nxt = S_START;
                    else                      w_state_nxt = S_ERR;
                end
                S_DIG: begin
                    if (w_is_dig)     w_state_nxt = S_OP;
                    else if (w_is_eq) w_state_nxt = S_START;
                    else              w_state_nxt = S_ERR;
                end
                default: begin
                    if (w_is_eq) w_state_nxt = S_START;
                end
            endcase
        end
    end

    // r_prod holds the running product of the current '+'-separated term
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state   <= S_START;
            r_sum     <= '0;
            r_prod    <= '0;
            r_mulpend <= 1'b0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_START);
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            if (bus.in_valid) begin
                case (r_state)
                    S_START: begin
                        if (w_is_dig) begin
                            r_sum     <= '0;
                            r_prod    <= w_d;
                            r_mulpend <= 1'b0;
                        end else if (w_is_eq) begin
                            r_done   <= 1'b1;
                            r_err    <= 1'b1;
                            r_result <= '0;
                        end
                    end
                    S_OP: begin
                        if (w_is_add) begin
                            r_sum     <= r_sum + r_prod;
                            r_prod    <= '0;
                            r_mulpend <= 1'b0;
                        end else if (w_is_mul) begin
                            r_mulpend <= 1'b1;
                        end else if (w_is_eq) begin
                            r_result <= r_sum + r_prod;
                            r_done   <= 1'b1;
                            r_err    <= 1'b0;
                            r_sum    <= '0;
                            r_prod   <= '0;
                        end
                    end
                    S_DIG: begin
                        if (w_is_dig) begin
                            r_prod <= r_mulpend ? r_prod * w_d : w_d;
                        end else if (w_is_eq) begin
                            r_done   <= 1'b1;
                            r_err    <= 1'b1;
                            r_result <= '0;
                        end
                    end
                    default: begin
                        if (w_is_eq) begin
                            r_done   <= 1'b1;
                            r_err    <= 1'b1;
                            r_result <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.result = r_result;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.busy   = r_busy;
endmodule

// File: tb/tb_expr_eval.sv
// tb/tb_expr_eval.sv - scoreboard bench for expr_eval at W=16 and W=8
module tb_expr_eval;
    typedef logic [7:0] ch_t;
    typedef struct {
        logic        err;
        int unsigned val;
    } exp_t;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    expr_eval_if #(.W(16)) bus16();
    expr_eval_if #(.W(8))  bus8();

    expr_eval #(.W(16)) dut16 (.clk(clk), .clr(clr), .bus(bus16.slave));
    expr_eval #(.W(8))  dut8  (.clk(clk), .clr(clr), .bus(bus8.slave));

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q16[$];
    exp_t q8[$];
    logic [15:0] last16 = '0;
    logic [7:0]  last8  = '0;

    // Reference: split into '+'-separated terms, each term a product of digits
    function automatic exp_t model(input ch_t e[$]);
        exp_t        r;
        int          n;
        int unsigned sum;
        int unsigned prod;
        n     = e.size() - 1;
        r.err = 1'b0;
        r.val = 0;
        if (n <= 0 || (n % 2) == 0) r.err = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) begin
                if (e[i] < "0" || e[i] > "9") r.err = 1'b1;
            end else if (e[i] != "+" && e[i] != "*") begin
                r.err = 1'b1;
            end
        end
        if (!r.err) begin
            sum  = 0;
            prod = int'(e[0] - "0");
            for (int i = 1; i < n; i += 2) begin
                if (e[i] == "+") begin
                    sum  = sum + prod;
                    prod = int'(e[i+1] - "0");
                end else begin
                    prod = prod * int'(e[i+1] - "0");
                end
            end
            r.val = sum + prod;
        end
        return r;
    endfunction

    task automatic drive(input ch_t c, input logic v);
        bus16.in       = c;
        bus16.in_valid = v;
        bus8.in        = c;
        bus8.in_valid  = v;
    endtask

    task automatic idle();
        drive(ch_t'($urandom), 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input ch_t c);
        logic exp_busy;
        drive(c, 1'b1);
        @(posedge clk);
        #1;
        drive(ch_t'($urandom), 1'b0);
        exp_busy = (c != "=");
        n_tests++;
        if (bus16.busy !== exp_busy || bus8.busy !== exp_busy) begin
            n_fail++;
            $display("FAIL busy after '%c': got %b/%b required %b", c, bus16.busy, bus8.busy, exp_busy);
        end
    endtask

    task automatic run_q(input ch_t e[$], input bit gaps);
        exp_t x;
        x = model(e);
        foreach (e[i]) begin
            if (gaps) repeat ($urandom_range(1, 2)) idle();
            if (e[i] == "=") begin
                q16.push_back(x);
                q8.push_back(x);
            end
            send(e[i]);
        end
    endtask

    task automatic run_str(input string s, input bit gaps);
        ch_t e[$];
        for (int i = 0; i < s.len(); i++) e.push_back(ch_t'(s[i]));
        run_q(e, gaps);
    endtask

    task automatic run_random(input bit gaps);
        ch_t   e[$];
        string pool;
        int    k;
        pool = "0123456789+*a ?/";
        if ($urandom_range(0, 3) != 0) begin
            k = $urandom_range(1, 5);
            e.push_back(ch_t'("0" + $urandom_range(0, 9)));
            repeat (k - 1) begin
                e.push_back($urandom_range(0, 1) ? ch_t'("+") : ch_t'("*"));
                e.push_back(ch_t'("0" + $urandom_range(0, 9)));
            end
        end else begin
            repeat ($urandom_range(0, 5)) e.push_back(ch_t'(pool[$urandom_range(0, pool.len() - 1)]));
        end
        e.push_back(ch_t'("="));
        run_q(e, gaps);
    endtask

    always @(negedge clk) begin
        exp_t x;
        n_tests++;
        if (bus16.done === 1'b1) begin
            if (q16.size() == 0) begin
                n_fail++;
                $display("FAIL done16_unexpected: done=1 required 0");
            end else begin
                x = q16.pop_front();
                if (bus16.err !== x.err || bus16.result !== (x.err ? 16'd0 : x.val[15:0])) begin
                    n_fail++;
                    $display("FAIL result16: got err=%b result=%0d required err=%b result=%0d",
                             bus16.err, bus16.result, x.err, x.err ? 16'd0 : x.val[15:0]);
                end
            end
            last16 = bus16.result;
        end else if (bus16.err !== 1'b0 || bus16.result !== last16 || bus16.done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle16: got done=%b err=%b result=%0d required done=0 err=0 result=%0d",
                     bus16.done, bus16.err, bus16.result, last16);
        end
        n_tests++;
        if (bus8.done === 1'b1) begin
            if (q8.size() == 0) begin
                n_fail++;
                $display("FAIL done8_unexpected: done=1 required 0");
            end else begin
                x = q8.pop_front();
                if (bus8.err !== x.err || bus8.result !== (x.err ? 8'd0 : x.val[7:0])) begin
                    n_fail++;
                    $display("FAIL result8: got err=%b result=%0d required err=%b result=%0d",
                             bus8.err, bus8.result, x.err, x.err ? 8'd0 : x.val[7:0]);
                end
            end
            last8 = bus8.result;
        end else if (bus8.err !== 1'b0 || bus8.result !== last8 || bus8.done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle8: got done=%b err=%b result=%0d required done=0 err=0 result=%0d",
                     bus8.done, bus8.err, bus8.result, last8);
        end
    end

    initial begin
        clr = 1'b0;
        drive("5", 1'b1);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus16.result !== 16'd0 || bus16.done !== 1'b0 || bus16.err !== 1'b0 || bus16.busy !== 1'b0
            || bus8.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got result=%0d done=%b err=%b busy=%b required 0 0 0 0",
                     bus16.result, bus16.done, bus16.err, bus16.busy);
        end
        clr = 1'b1;
        idle();

        run_str("3+4*5=", 1'b0);
        idle();
        run_str("2*3*4+1=", 1'b1);
        idle();
        run_str("3++4=", 1'b0);
        run_str("7=", 1'b0);
        run_str("=", 1'b0);
        run_str("9*9*9*9=", 1'b0);
        run_str("a3+4=", 1'b0);
        run_str("34=", 1'b0);
        run_str("3+=", 1'b0);

        send("3");
        send("+");
        send("4");
        drive("=", 1'b1);
        clr = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b1;
        drive(8'h00, 1'b0);
        n_tests++;
        if (bus16.busy !== 1'b0 || bus16.done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: got busy=%b done=%b required 0 0", bus16.busy, bus16.done);
        end
        run_str("2=", 1'b0);

        for (int i = 0; i < 200; i++) run_random($urandom_range(0, 3) == 0);

        repeat (5) idle();
        n_tests++;
        if (q16.size() != 0 || q8.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending %0d/%0d required 0", q16.size(), q8.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
